// File: rtl/split_pipe_if.sv
// Native request/response bus bundle for split_pipe: N_PORTS packed slots of
// {valid, addr, wdata, wstrb} requests and {rdata, ready} responses.
interface split_pipe_if #(
    parameter int unsigned N_PORTS = 1,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
);
    localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int unsigned RESP_W = DATA_W + 1;

    logic [N_PORTS*REQ_W-1:0]  req;
    logic [N_PORTS*RESP_W-1:0] resp;

    modport master (output req, input  resp);
    modport slave  (input  req, output resp);
endinterface

// File: rtl/split_pipe.sv
// Registered 1-to-N native-bus splitter with error response for unmapped selects.
// Define SPLIT_PIPE_TIMEOUT_EN to add a per-transaction BUSY timeout.
module split_pipe #(
    parameter int unsigned N_SLAVES  = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned P_SLAVES  = ADDR_W - 1,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    split_pipe_if.slave  m,
    split_pipe_if.master s,
    output logic         err
);
    localparam int unsigned REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int unsigned RESP_W = DATA_W + 1;
    localparam int unsigned NB     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam logic [NB:0] N_LIM  = (NB + 1)'(N_SLAVES);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                    state;
    logic [N_SLAVES*REQ_W-1:0] s_req_q;
    logic [RESP_W-1:0]         m_resp_q;
    logic [NB-1:0]             sel_q;
    logic [NB-1:0]             m_sel;
    logic                      m_valid;
    logic                      mapped;
    logic                      s_ready;
    logic [DATA_W-1:0]         s_rdata;

`ifdef SPLIT_PIPE_TIMEOUT_EN
    // Last count value before the limit: timeout fires on the edge that would reach 2^W-1.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);
    logic [TIMEOUT_W-1:0] cnt;
`endif

    assign m_valid = m.req[REQ_W-1];
    assign m_sel   = m.req[REQ_W-1-ADDR_W+P_SLAVES -: NB];
    assign mapped  = ({1'b0, m_sel} < N_LIM);

    assign s.req  = s_req_q;
    assign m.resp = m_resp_q;

    // Response mux keyed only by the latched select, never the live address.
    always_comb begin
        s_ready = 1'b0;
        s_rdata = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (sel_q == NB'(i)) begin
                s_ready = s.resp[i*RESP_W];
                s_rdata = s.resp[i*RESP_W+1 +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_req_q  <= '0;
            m_resp_q <= '0;
            err      <= 1'b0;
            sel_q    <= '0;
`ifdef SPLIT_PIPE_TIMEOUT_EN
            cnt      <= '0;
`endif
        end else begin
            m_resp_q <= '0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        if (mapped) begin
                            for (int unsigned i = 0; i < N_SLAVES; i++) begin
                                if (m_sel == NB'(i)) s_req_q[i*REQ_W +: REQ_W] <= m.req;
                            end
                            sel_q <= m_sel;
`ifdef SPLIT_PIPE_TIMEOUT_EN
                            cnt   <= '0;
`endif
                            state <= BUSY;
                        end else begin
                            m_resp_q <= {{DATA_W{1'b0}}, 1'b1};
                            err      <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        s_req_q  <= '0;
                        m_resp_q <= {s_rdata, 1'b1};
                        state    <= RESP;
                    end
`ifdef SPLIT_PIPE_TIMEOUT_EN
                    else if (cnt == TO_LAST) begin
                        s_req_q  <= '0;
                        m_resp_q <= {{DATA_W{1'b1}}, 1'b1};
                        err      <= 1'b1;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
